rr_arbiter_2: RTL and testbench

- Two-client round-robin arbiter with bounded grant hold.
- Sits directly downstream of the request stimulus/requesters: consumes req0/req1 and returns registered, mutually exclusive gnt0/gnt1.
- A hold limit stops one client from monopolising the shared resource while the other is waiting.

---
 rtl/rr_arbiter_2_pkg.sv | 18 +
 rtl/rr_arbiter_2_hold_counter.sv | 41 ++++
 rtl/rr_arbiter_2.sv | 102 ++++++++++
 tb/tb_rr_arbiter_2.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_2_pkg.sv
// Shared definitions for the two-client round-robin arbiter: state encoding,
// default hold limits and a small helper mapping a client id to its grant state.
package rr_arbiter_2_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam int unsigned ARB_MAX_HOLD_DEFAULT = 4;
    localparam int unsigned ARB_CNT_W_DEFAULT    = 3;

    function automatic arb_state_e grant_state(input logic id);
        return id ? ARB_GNT1 : ARB_GNT0;
    endfunction

endpackage

// File: rtl/rr_arbiter_2_hold_counter.sv
// Saturating hold counter for the arbiter: counts contended cycles of the
// current grant and flags when the owner has reached its hold limit.
module arb_hold_counter
    import rr_arbiter_2_pkg::*;
#(
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
    parameter int unsigned CNT_W    = ARB_CNT_W_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic limit_hit
);

    // MAX_HOLD == 0 means unlimited: the counter is pinned at zero.
    localparam logic [CNT_W-1:0] LIMIT = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (MAX_HOLD == 0)) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_hit = (MAX_HOLD != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-client round-robin arbiter with bounded grant hold. Grants are Moore
// outputs decoded from the registered state, so they are mutually exclusive.
module rr_arbiter_2
    import rr_arbiter_2_pkg::*;
#(
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
    parameter int unsigned CNT_W    = ARB_CNT_W_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic busy,
    output logic last_id
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_id_q;
    logic       last_id_d;
    logic       hold_clear;
    logic       hold_en;
    logic       limit_hit;

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (hold_clear),
        .en        (hold_en),
        .limit_hit (limit_hit)
    );

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        hold_clear = 1'b1;
        hold_en    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (req0 && req1) begin
                    state_d = grant_state(~last_id_q);
                end else if (req0) begin
                    state_d = ARB_GNT0;
                end else if (req1) begin
                    state_d = ARB_GNT1;
                end
            end
            // A dropped owner request wins over an expiring hold limit.
            ARB_GNT0: begin
                if (!req0) begin
                    state_d = req1 ? ARB_GNT1 : ARB_IDLE;
                end else if (req1 && limit_hit) begin
                    state_d = ARB_GNT1;
                end else begin
                    hold_clear = !req1;
                    hold_en    = req1;
                end
            end
            ARB_GNT1: begin
                if (!req1) begin
                    state_d = req0 ? ARB_GNT0 : ARB_IDLE;
                end else if (req0 && limit_hit) begin
                    state_d = ARB_GNT0;
                end else begin
                    hold_clear = !req0;
                    hold_en    = req0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (state_d == ARB_GNT0) begin
            last_id_d = 1'b0;
        end else if (state_d == ARB_GNT1) begin
            last_id_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
        end
    end

    assign gnt0    = (state_q == ARB_GNT0);
    assign gnt1    = (state_q == ARB_GNT1);
    assign busy    = gnt0 | gnt1;
    assign last_id = last_id_q;

endmodule

// File: tb/tb_rr_arbiter_2.sv
// Scoreboard bench for rr_arbiter_2: a behavioural model pushes the expected
// {gnt0,gnt1,busy,last_id} when requests are driven; tasks pop and compare.
module tb_rr_arbiter_2;

    localparam int unsigned MH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic req0  = 1'b0;
    logic req1  = 1'b0;
    logic gnt0, gnt1, busy, last_id;
    logic req0_b = 1'b0;
    logic req1_b = 1'b0;
    logic gnt0_b, gnt1_b, busy_b, last_id_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_b_q[$];
    logic [3:0] got;
    logic [3:0] exp;

    int          m_state;
    int unsigned m_cnt;
    logic        m_last;

    always #5 clock = ~clock;

    rr_arbiter_2 #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .last_id(last_id)
    );

    rr_arbiter_2 #(.MAX_HOLD(0), .CNT_W(3)) dut_unl (
        .clock(clock), .reset(reset), .req0(req0_b), .req1(req1_b),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .busy(busy_b), .last_id(last_id_b)
    );

    always @(negedge clock) begin
        if (reset) begin
            n_checks++;
            if ((gnt0 && gnt1) || (busy !== (gnt0 | gnt1))) begin
                n_fail++;
                $display("FAIL invariant_a g0=%b g1=%b busy=%b", gnt0, gnt1, busy);
            end
            n_checks++;
            if ((gnt0_b && gnt1_b) || (busy_b !== (gnt0_b | gnt1_b))) begin
                n_fail++;
                $display("FAIL invariant_b g0=%b g1=%b busy=%b", gnt0_b, gnt1_b, busy_b);
            end
        end
    end

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_last  = 1'b1;
        exp_q.delete();
    endtask

    task automatic model_step(input logic r0, input logic r1);
        int   nxt;
        int   other_st;
        logic own;
        logic oth;
        nxt      = m_state;
        own      = (m_state == 1) ? r0 : r1;
        oth      = (m_state == 1) ? r1 : r0;
        other_st = (m_state == 1) ? 2 : 1;
        if (m_state == 0) begin
            if (r0 && r1)  nxt = m_last ? 1 : 2;
            else if (r0)   nxt = 1;
            else if (r1)   nxt = 2;
        end else begin
            if (!own)                                         nxt = oth ? other_st : 0;
            else if (oth && MH != 0 && m_cnt == MH - 1)       nxt = other_st;
        end
        if (nxt != m_state || m_state == 0 || !oth) m_cnt = 0;
        else if (m_cnt < MH - 1)                    m_cnt = m_cnt + 1;
        if (nxt == 1) m_last = 1'b0;
        if (nxt == 2) m_last = 1'b1;
        m_state = nxt;
        exp_q.push_back({(nxt == 1), (nxt == 2), (nxt != 0), m_last});
    endtask

    task automatic drive(input logic r0, input logic r1);
        req0 = r0;
        req1 = r1;
        model_step(r0, r1);
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        @(posedge clock); #1;
        got = {gnt0, gnt1, busy, last_id};
        n_checks++;
        if (got !== 4'b0001) begin
            n_fail++; $display("FAIL reset_state got=%b exp=0001", got);
        end
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clock); #1;
        got = {gnt0, gnt1, busy, last_id};
        n_checks++;
        if (got !== 4'b0001) begin
            n_fail++; $display("FAIL req_during_reset got=%b exp=0001", got);
        end
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 1'b1);
        got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp || got !== 4'b1010) begin
            n_fail++; $display("FAIL first_tie got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_reset_mid_grant();
        pulse_reset();
        drive(1'b1, 1'b0);
        got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL midgrant_pre got=%b exp=%b", got, exp);
        end
        #2;
        reset = 1'b0;
        #1;
        got = {gnt0, gnt1, busy, last_id};
        n_checks++;
        if (got !== 4'b0001) begin
            n_fail++; $display("FAIL async_reset got=%b exp=0001", got);
        end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        drive(1'b1, 1'b0);
        got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp || gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL midgrant_post got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_single_requester();
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0);
            got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp || gnt0 !== 1'b1) begin
                n_fail++; $display("FAIL single_req cyc=%0d got=%b exp=%b", i, got, exp);
            end
        end
        drive(1'b0, 1'b0);
        got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_drop got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_tie_rotation();
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1);
            got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp || gnt0 !== (((i / 4) % 2) == 0)) begin
                n_fail++; $display("FAIL tie_rotation cyc=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_direct_handover();
        // Follows the rotation: gnt1 is active with req0 pending.
        drive(1'b1, 1'b0);
        got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp || got !== 4'b1010) begin
            n_fail++; $display("FAIL direct_handover got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_release_at_limit();
        for (int k = 0; k < 2; k++) begin
            pulse_reset();
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, 1'b1);
                got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp || gnt0 !== 1'b1) begin
                    n_fail++; $display("FAIL limit_setup k=%0d cyc=%0d got=%b exp=%b", k, i, got, exp);
                end
            end
            drive(1'b0, (k == 1));
            got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp || got !== ((k == 0) ? 4'b0000 : 4'b0111)) begin
                n_fail++; $display("FAIL release_at_limit k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic r0, r1;
        pulse_reset();
        r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) r0 = ~r0;
            if ($urandom_range(0, 3) == 0) r1 = ~r1;
            drive(r0, r1);
            got = {gnt0, gnt1, busy, last_id}; exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_unlimited();
        pulse_reset();
        exp_b_q.delete();
        req0_b = 1'b1; req1_b = 1'b1;
        for (int i = 0; i < 50; i++) begin
            exp_b_q.push_back(4'b1010);
            @(posedge clock); #1;
            got = {gnt0_b, gnt1_b, busy_b, last_id_b}; exp = exp_b_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL unlimited_hold cyc=%0d got=%b exp=%b", i, got, exp);
            end
        end
        req0_b = 1'b0;
        exp_b_q.push_back(4'b0111);
        @(posedge clock); #1;
        got = {gnt0_b, gnt1_b, busy_b, last_id_b}; exp = exp_b_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL unlimited_handover got=%b exp=%b", got, exp);
        end
        req1_b = 1'b0;
        exp_b_q.push_back(4'b0001);
        @(posedge clock); #1;
        got = {gnt0_b, gnt1_b, busy_b, last_id_b}; exp = exp_b_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL unlimited_idle got=%b exp=%b", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_grant();
        test_single_requester();
        test_tie_rotation();
        test_direct_handover();
        test_release_at_limit();
        test_random();
        test_unlimited();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
